// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// mem_port_arbiter
// Shares one variable-latency memory port between fetch and MEM-stage data.
// Revision: 1.0
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rdy,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic              bus_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_FETCH = 2'd2
    } state_t;

    localparam logic [15:0] c_TMO_LAST = 16'(TIMEOUT - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [15:0]       r_tcnt;
    logic              r_d_done;
    logic              r_if_done;
    logic [DATA_W-1:0] r_d_q;
    logic [DATA_W-1:0] r_if_q;

    logic              w_mem_req_nxt;
    logic              w_mem_we_nxt;
    logic [ADDR_W-1:0] w_mem_addr_nxt;
    logic [DATA_W-1:0] w_mem_wdata_nxt;
    logic [15:0]       w_tcnt_nxt;

    logic              w_d_pend;
    logic              w_if_pend;
    logic              w_busy;
    logic              w_tmo;
    logic              w_done;
    logic [DATA_W-1:0] w_rdata;
    logic              w_d_ack;
    logic              w_if_ack;
    logic              w_stall;

    // Done flags suppress re-issue of an already served access while frozen.
    always_comb begin
        w_d_pend  = (d_rd | d_wr) & ~r_d_done;
        w_if_pend = if_req & ~r_if_done;
        w_busy    = (r_state != ST_IDLE);
        w_tmo     = w_busy & ~rst & ~mem_rdy & (r_tcnt == c_TMO_LAST);
        w_done    = w_busy & ~rst & (mem_rdy | w_tmo);
        w_rdata   = w_tmo ? '0 : mem_rdata;
        w_d_ack   = (r_state == ST_DATA)  & w_done;
        w_if_ack  = (r_state == ST_FETCH) & w_done;
        w_stall   = (w_d_pend & ~w_d_ack) | (w_if_pend & ~w_if_ack);
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_tcnt_nxt      = r_tcnt;
        case (r_state)
            ST_IDLE: begin
                w_mem_req_nxt = 1'b0;
                if (w_d_pend) begin
                    w_state_nxt     = ST_DATA;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = d_wr;
                    w_mem_addr_nxt  = d_addr;
                    w_mem_wdata_nxt = d_wdata;
                    w_tcnt_nxt      = '0;
                end else if (w_if_pend) begin
                    w_state_nxt    = ST_FETCH;
                    w_mem_req_nxt  = 1'b1;
                    w_mem_we_nxt   = 1'b0;
                    w_mem_addr_nxt = if_addr;
                    w_tcnt_nxt     = '0;
                end
            end
            ST_DATA, ST_FETCH: begin
                if (w_done) begin
                    // A fetch queued behind data goes out without an idle gap.
                    if ((r_state == ST_DATA) && w_if_pend && w_stall) begin
                        w_state_nxt    = ST_FETCH;
                        w_mem_we_nxt   = 1'b0;
                        w_mem_addr_nxt = if_addr;
                        w_tcnt_nxt     = '0;
                    end else begin
                        w_state_nxt   = ST_IDLE;
                        w_mem_req_nxt = 1'b0;
                    end
                end else begin
                    w_tcnt_nxt = r_tcnt + 16'd1;
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_mem_req_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_tcnt      <= '0;
            r_d_done    <= 1'b0;
            r_if_done   <= 1'b0;
            r_d_q       <= '0;
            r_if_q      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_tcnt      <= w_tcnt_nxt;
            if (w_d_ack) begin
                r_d_q <= w_rdata;
            end
            if (w_if_ack) begin
                r_if_q <= w_rdata;
            end
            if (!w_stall) begin
                r_d_done  <= 1'b0;
                r_if_done <= 1'b0;
            end else begin
                if (w_d_ack) begin
                    r_d_done <= 1'b1;
                end
                if (w_if_ack) begin
                    r_if_done <= 1'b1;
                end
            end
        end
    end

    assign if_ack    = w_if_ack;
    assign if_rdata  = w_if_ack ? w_rdata : r_if_q;
    assign d_ack     = w_d_ack;
    assign d_rdata   = w_d_ack ? w_rdata : r_d_q;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign stall     = w_stall;
    assign bus_err   = w_tmo;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_mem_port_arbiter
// Scoreboard bench: expected memory transactions and read data are queued at
// issue time and consumed when the arbiter completes / acknowledges.
// Revision: 1.0
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_ack, d_rd, d_wr, d_ack;
    logic        mem_req, mem_we, mem_rdy, stall, bus_err;
    logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdy(mem_rdy), .mem_rdata(mem_rdata),
        .stall(stall), .bus_err(bus_err)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } txn_t;

    typedef struct {
        bit          chk;
        logic [31:0] v;
    } rd_t;

    txn_t txn_q[$];
    rd_t  dq[$];
    rd_t  iq[$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_txn    = 0;
    int busy_cnt = 0;
    int lat      = 1;
    bit stuck    = 1'b0;
    bit force_rdy = 1'b0;
    int cidx     = 0;
    bit tr_stall[64], tr_req[64], tr_we[64], tr_dack[64], tr_iack[64], tr_berr[64];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mdl(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEADBEEF;
        return (a ^ 32'h5A5A_0000) + 32'h0000_1111;
    endfunction

    // Memory model: mem_rdy after `lat` busy cycles unless stuck.
    task automatic cyc_begin();
        @(posedge clk);
        #1;
        if (mem_req) busy_cnt++;
        else busy_cnt = 0;
        mem_rdy   = force_rdy || (mem_req && !stuck && busy_cnt >= lat);
        mem_rdata = mdl(mem_addr);
    endtask

    task automatic cyc_end();
        rd_t  r;
        txn_t t;
        @(negedge clk);
        if (cidx < 64) begin
            tr_stall[cidx] = stall;
            tr_req[cidx]   = mem_req;
            tr_we[cidx]    = mem_we;
            tr_dack[cidx]  = d_ack;
            tr_iack[cidx]  = if_ack;
            tr_berr[cidx]  = bus_err;
        end
        cidx++;
        if (d_ack) begin
            check("d_ack_expected", dq.size() != 0, 1'b1);
            if (dq.size() != 0) begin
                r = dq.pop_front();
                if (r.chk) check("d_rdata", d_rdata, r.v);
            end
        end
        if (if_ack) begin
            check("if_ack_expected", iq.size() != 0, 1'b1);
            if (iq.size() != 0) begin
                r = iq.pop_front();
                check("if_rdata", if_rdata, r.v);
            end
        end
        if (mem_req && (mem_rdy || bus_err)) begin
            n_txn++;
            busy_cnt = 0;
            check("txn_expected", txn_q.size() != 0, 1'b1);
            if (txn_q.size() != 0) begin
                t = txn_q.pop_front();
                check("mem_addr", mem_addr, t.addr);
                check("mem_we", mem_we, t.we);
                if (t.we) check("mem_wdata", mem_wdata, t.wdata);
            end
        end
    endtask

    task automatic drive(input bit rd, input bit wr, input logic [31:0] da,
                         input logic [31:0] wd, input bit ireq, input logic [31:0] ia);
        d_rd = rd; d_wr = wr; d_addr = da; d_wdata = wd;
        if_req = ireq; if_addr = ia;
    endtask

    task automatic idle_cycle();
        cyc_begin();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        cyc_end();
    endtask

    // Holds one pipeline slot's requests until stall drops, like a frozen pipeline.
    task automatic issue(input bit rd, input bit wr, input logic [31:0] da, input logic [31:0] wd,
                         input bit ireq, input logic [31:0] ia, input bit tmo, output int ncyc);
        bit s;
        if (rd || wr) begin
            txn_q.push_back('{da, wr, wd});
            dq.push_back('{rd, tmo ? 32'h0 : mdl(da)});
        end
        if (ireq) begin
            txn_q.push_back('{ia, 1'b0, 32'h0});
            iq.push_back('{1'b1, tmo ? 32'h0 : mdl(ia)});
        end
        cidx = 0;
        ncyc = 0;
        do begin
            cyc_begin();
            drive(rd, wr, da, wd, ireq, ia);
            cyc_end();
            s = stall;
            ncyc++;
        end while (s && ncyc < 40);
        if (s) check("issue_bound", 1'b1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, n2, t0;
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        mem_rdy = 1'b0;
        mem_rdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_stall", stall, 1'b0);
        check("rst_bus_err", bus_err, 1'b0);
        check("rst_d_rdata", d_rdata, 32'h0);
        cyc_begin();
        rst = 1'b0;
        cyc_end();

        // Load with mem_rdy on the 2nd busy cycle
        lat = 2;
        issue(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0, 1'b0, n);
        check("t1_cycles", n, 3);
        check("t1_stall0", tr_stall[0], 1'b1);
        check("t1_stall1", tr_stall[1], 1'b1);
        check("t1_stall2", tr_stall[2], 1'b0);
        check("t1_req0", tr_req[0], 1'b0);
        check("t1_req1", tr_req[1], 1'b1);
        check("t1_req2", tr_req[2], 1'b1);
        check("t1_we1", tr_we[1], 1'b0);
        check("t1_dack1", tr_dack[1], 1'b0);
        check("t1_dack2", tr_dack[2], 1'b1);
        idle_cycle();
        check("t1_req_after", mem_req, 1'b0);
        check("t1_d_hold", d_rdata, 32'hDEADBEEF);

        // Store and fetch in the same cycle: data first
        lat = 1;
        t0 = n_txn;
        issue(1'b0, 1'b1, 32'h20, 32'h12345678, 1'b1, 32'h400, 1'b0, n);
        check("t2_cycles", n, 3);
        check("t2_we1", tr_we[1], 1'b1);
        check("t2_dack1", tr_dack[1], 1'b1);
        check("t2_iack1", tr_iack[1], 1'b0);
        check("t2_iack2", tr_iack[2], 1'b1);
        check("t2_stall1", tr_stall[1], 1'b1);
        check("t2_stall2", tr_stall[2], 1'b0);
        idle_cycle();
        check("t2_txn_count", n_txn - t0, 2);
        check("t2_req_after", mem_req, 1'b0);

        // Fetch only; if_rdata holds after the request drops
        issue(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h800, 1'b0, n);
        check("t3_cycles", n, 2);
        check("t3_iack1", tr_iack[1], 1'b1);
        idle_cycle();
        idle_cycle();
        check("t3_if_hold", if_rdata, mdl(32'h800));

        // Timeout with mem_rdy stuck low
        stuck = 1'b1;
        issue(1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 32'h0, 1'b1, n);
        stuck = 1'b0;
        check("t4_cycles", n, 5);
        check("t4_berr3", tr_berr[3], 1'b0);
        check("t4_berr4", tr_berr[4], 1'b1);
        check("t4_dack4", tr_dack[4], 1'b1);
        idle_cycle();
        check("t4_req_after", mem_req, 1'b0);
        check("t4_berr_after", bus_err, 1'b0);
        check("t4_d_hold", d_rdata, 32'h0);
        issue(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h900, 1'b0, n);
        check("t4_fetch_after", n, 2);

        // Reset during the 2nd busy cycle of a load; late mem_rdy ignored
        lat = 10;
        cyc_begin(); drive(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0); cyc_end();
        cyc_begin(); cyc_end();
        check("t5_req_busy", mem_req, 1'b1);
        check("t5_stall_busy", stall, 1'b1);
        cyc_begin(); rst = 1'b1; drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0); cyc_end();
        cyc_begin(); rst = 1'b0; force_rdy = 1'b1; cyc_end();
        check("t5_req_after", mem_req, 1'b0);
        check("t5_stall_after", stall, 1'b0);
        check("t5_no_dack", d_ack, 1'b0);
        check("t5_no_iack", if_ack, 1'b0);
        check("t5_d_rdata", d_rdata, 32'h0);
        force_rdy = 1'b0;
        lat = 1;
        idle_cycle();

        // Back-to-back loads
        t0 = n_txn;
        issue(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, n);
        issue(1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 32'h0, 1'b0, n2);
        check("t6_cycles_a", n, 2);
        check("t6_cycles_b", n2, 2);
        idle_cycle();
        idle_cycle();
        check("t6_txn_count", n_txn - t0, 2);
        check("t6_req_after", mem_req, 1'b0);
        check("t6_d_hold", d_rdata, mdl(32'h4));

        check("txn_q_empty", txn_q.size(), 0);
        check("dq_empty", dq.size(), 0);
        check("iq_empty", iq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
